// File: rtl/trace_pkg.sv
// Shared record format for the commit trace unit: field layout, wire framing
// and the record-to-byte packing used by the serializer.
package trace_pkg;

  localparam int         TRACE_DATA_W = 32;
  localparam int         REC_BYTES    = 14;
  localparam logic [7:0] HDR_SOP      = 8'h80;

  typedef struct packed {
    logic                    ovf;
    logic                    reade;
    logic                    wr;
    logic                    rf_we;
    logic [15:0]             ts;
    logic [4:0]              reg_num;
    logic [TRACE_DATA_W-1:0] reg_data;
    logic [15:0]             addr16;
    logic [TRACE_DATA_W-1:0] mem_data;
  } trace_rec_t;

  // Byte 0 ends up in the low bits so the serializer can simply shift right.
  function automatic logic [8*REC_BYTES-1:0] pack_bytes(input trace_rec_t rec);
    logic [7:0] hdr;
    hdr = HDR_SOP | {1'b0, rec.ovf, 3'b000, rec.reade, rec.wr, rec.rf_we};
    return {rec.mem_data, rec.addr16, rec.reg_data, 3'b000, rec.reg_num, rec.ts, hdr};
  endfunction

endpackage

// File: rtl/commit_trace_unit_if.sv
// Byte stream carrying trace records from the unit to a bench or debug UART.
interface commit_trace_unit_if;

  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;

  modport master (output tx_data, output tx_valid, input tx_ready);
  modport slave  (input tx_data, input tx_valid, output tx_ready);

endinterface

// File: rtl/trace_fifo.sv
// Synchronous single-clock FIFO holding whole trace records.
module trace_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign level = wr_ptr - rd_ptr;
  assign full  = level[AW];
  assign empty = (wr_ptr == rd_ptr);
  assign rdata = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push && !full) begin
        mem[wr_ptr[AW-1:0]] <= wdata;
        wr_ptr              <= wr_ptr + (AW+1)'(1);
      end
      if (pop && !empty) begin
        rd_ptr <= rd_ptr + (AW+1)'(1);
      end
    end
  end

endmodule

// File: rtl/commit_trace_unit.sv
// Captures writeback and data-memory activity into 14-byte trace records,
// queues them and streams them out byte by byte over a valid/ready link.
module commit_trace_unit
  import trace_pkg::*;
#(
  parameter int FIFO_DEPTH = 8,
  parameter int DATA_W     = TRACE_DATA_W,
  parameter int DM_ADDRESS = 9,
  parameter int TS_W       = 16
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        trace_en,
  input  logic                        reg_write_sig,
  input  logic [4:0]                  reg_num,
  input  logic [DATA_W-1:0]           reg_data,
  input  logic                        wr,
  input  logic                        reade,
  input  logic [DM_ADDRESS-1:0]       addr,
  input  logic [DATA_W-1:0]           wr_data,
  input  logic [DATA_W-1:0]           rd_data,
  commit_trace_unit_if.master         tx,
  output logic                        overflow_sticky,
  output logic [15:0]                 drop_cnt,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level
);

  localparam int         REC_W    = $bits(trace_rec_t);
  localparam int         SR_W     = 8 * REC_BYTES;
  localparam logic [3:0] LAST_IDX = 4'(REC_BYTES - 1);

  typedef enum logic {IDLE, SEND} ser_state_t;

  ser_state_t      state;
  logic [3:0]      idx;
  logic [SR_W-1:0] shreg;
  logic            tx_valid_q;
  logic [TS_W-1:0] ts;
  logic            pending_ovf;
  logic            rf_we;
  logic            capture;
  logic            push;
  logic            pop;
  logic            fifo_full;
  logic            fifo_empty;
  trace_rec_t      rec_in;
  trace_rec_t      rec_out;

  // A write to x0 is architecturally a no-op, so it does not count as activity.
  assign rf_we   = reg_write_sig && (reg_num != 5'd0);
  assign capture = trace_en && (rf_we || wr || reade);
  assign push    = capture && !fifo_full;
  assign pop     = !fifo_empty &&
                   ((state == IDLE) || (tx.tx_ready && idx == LAST_IDX));

  always_comb begin
    rec_in          = '0;
    rec_in.ovf      = pending_ovf;
    rec_in.reade    = reade;
    rec_in.wr       = wr;
    rec_in.rf_we    = rf_we;
    rec_in.ts       = ts;
    rec_in.reg_num  = reg_num;
    rec_in.reg_data = reg_data;
    rec_in.addr16   = 16'(addr);
    rec_in.mem_data = wr ? wr_data : rd_data;
  end

  trace_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (REC_W)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .wdata (rec_in),
    .rdata (rec_out),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (fifo_level)
  );

  // A drop is remembered so the next record that makes it in is flagged.
  always_ff @(posedge clk) begin
    if (reset) begin
      ts              <= '0;
      drop_cnt        <= '0;
      overflow_sticky <= 1'b0;
      pending_ovf     <= 1'b0;
    end else begin
      ts <= ts + TS_W'(1);
      if (capture && fifo_full) begin
        if (drop_cnt != 16'hFFFF) begin
          drop_cnt <= drop_cnt + 16'd1;
        end
        overflow_sticky <= 1'b1;
        pending_ovf     <= 1'b1;
      end else if (push) begin
        pending_ovf <= 1'b0;
      end
    end
  end

  // On the last byte the next record is loaded directly so packets run back to back.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      idx        <= '0;
      shreg      <= '0;
      tx_valid_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (!fifo_empty) begin
            shreg      <= pack_bytes(rec_out);
            idx        <= '0;
            tx_valid_q <= 1'b1;
            state      <= SEND;
          end
        end
        SEND: begin
          if (tx.tx_ready) begin
            if (idx != LAST_IDX) begin
              shreg <= shreg >> 8;
              idx   <= idx + 4'd1;
            end else if (!fifo_empty) begin
              shreg <= pack_bytes(rec_out);
              idx   <= '0;
            end else begin
              shreg      <= '0;
              idx        <= '0;
              tx_valid_q <= 1'b0;
              state      <= IDLE;
            end
          end
        end
        default: begin
          state      <= IDLE;
          tx_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign tx.tx_data  = shreg[7:0];
  assign tx.tx_valid = tx_valid_q;

endmodule

// File: tb/tb_commit_trace_unit.sv
// Directed bench for commit_trace_unit: record layout, latency, backpressure,
// overflow flagging, back-to-back streaming and reset mid-packet.
module tb_commit_trace_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        trace_en;
  logic        reg_write_sig;
  logic [4:0]  reg_num;
  logic [31:0] reg_data;
  logic        wr;
  logic        reade;
  logic [8:0]  addr;
  logic [31:0] wr_data;
  logic [31:0] rd_data;
  logic        overflow_sticky;
  logic [15:0] drop_cnt;
  logic [3:0]  fifo_level;

  commit_trace_unit_if tx_if ();

  commit_trace_unit #(
    .FIFO_DEPTH (8),
    .DATA_W     (32),
    .DM_ADDRESS (9),
    .TS_W       (16)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .trace_en        (trace_en),
    .reg_write_sig   (reg_write_sig),
    .reg_num         (reg_num),
    .reg_data        (reg_data),
    .wr              (wr),
    .reade           (reade),
    .addr            (addr),
    .wr_data         (wr_data),
    .rd_data         (rd_data),
    .tx              (tx_if),
    .overflow_sticky (overflow_sticky),
    .drop_cnt        (drop_cnt),
    .fifo_level      (fifo_level)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Every accepted byte is logged with the cycle it was accepted in.
  logic [7:0] rx_byte [$];
  int         rx_cyc  [$];
  always @(negedge clk) begin
    if (!reset && tx_if.tx_valid && tx_if.tx_ready) begin
      rx_byte.push_back(tx_if.tx_data);
      rx_cyc.push_back(cyc);
    end
  end

  int checks = 0;
  int errors = 0;
  int rel_cyc = 0;
  int ev_cyc = 0;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] byteAt(input int i);
    if (i < rx_byte.size()) return rx_byte[i];
    return 8'hxx;
  endfunction

  function automatic int cycAt(input int i);
    if (i < rx_cyc.size()) return rx_cyc[i];
    return -1000;
  endfunction

  function automatic logic [15:0] tsAt(input int c);
    return 16'(c - rel_cyc);
  endfunction

  task automatic rxClear();
    rx_byte.delete();
    rx_cyc.delete();
  endtask

  // Drives one cycle of core activity, then returns the inputs to quiet.
  task automatic applyStimulus(input logic rw, input logic [4:0] rn, input logic [31:0] rd,
                               input logic w, input logic r, input logic [8:0] a,
                               input logic [31:0] wd, input logic [31:0] rdd);
    reg_write_sig = rw; reg_num = rn; reg_data = rd;
    wr = w; reade = r; addr = a; wr_data = wd; rd_data = rdd;
    ev_cyc = cyc;
    tick();
    reg_write_sig = 1'b0; reg_num = '0; reg_data = '0;
    wr = 1'b0; reade = 1'b0; addr = '0; wr_data = '0; rd_data = '0;
  endtask

  task automatic doReset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    rel_cyc = cyc;
    rxClear();
  endtask

  task automatic waitBytes(input int n, input int budget);
    int t = 0;
    while (rx_byte.size() < n && t < budget) begin
      tick();
      t++;
    end
    checkOutput("byte_count", rx_byte.size(), n);
  endtask

  task automatic checkBytes(input string tag, input int base, input logic [111:0] exp);
    for (int i = 0; i < 14; i++) begin
      checkOutput($sformatf("%s_b%0d", tag, i), byteAt(base + i), exp[8*i +: 8]);
    end
  endtask

  initial begin
    logic [15:0] ts_e;
    logic [15:0] ts_a;
    logic [15:0] ts_b;
    int          t;

    reset = 1'b1; trace_en = 1'b1;
    reg_write_sig = 1'b0; reg_num = '0; reg_data = '0;
    wr = 1'b0; reade = 1'b0; addr = '0; wr_data = '0; rd_data = '0;
    tx_if.tx_ready = 1'b1;

    doReset();
    checkOutput("rst_tx_valid", tx_if.tx_valid, 0);
    checkOutput("rst_tx_data", tx_if.tx_data, 0);
    checkOutput("rst_sticky", overflow_sticky, 0);
    checkOutput("rst_drop_cnt", drop_cnt, 0);
    checkOutput("rst_level", fifo_level, 0);

    // Writeback to x5 at ts=3, checked against the literal byte sequence.
    tick(); tick(); tick();
    applyStimulus(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 1'b0, 9'h0, 32'h0, 32'h0);
    waitBytes(14, 40);
    checkBytes("rec1", 0, 112'h00000000_0000_DEADBEEF_05_0003_81);
    checkOutput("lat_first", cycAt(0) - ev_cyc, 2);
    checkOutput("lat_last", cycAt(13) - ev_cyc, 15);

    // x0 write alongside a store: only the store flag is set.
    rxClear();
    applyStimulus(1'b1, 5'd0, 32'hCAFEF00D, 1'b1, 1'b0, 9'h1F4, 32'h11223344, 32'h55667788);
    ts_e = tsAt(ev_cyc);
    waitBytes(14, 40);
    checkBytes("store", 0, {32'h11223344, 16'h01F4, 32'hCAFEF00D, 8'h00, ts_e, 8'h82});

    // x0 write alone and activity with capture disabled produce nothing.
    rxClear();
    applyStimulus(1'b1, 5'd0, 32'h12345678, 1'b0, 1'b0, 9'h0, 32'h0, 32'h0);
    checkOutput("x0_level", fifo_level, 0);
    trace_en = 1'b0;
    applyStimulus(1'b1, 5'd6, 32'h1, 1'b1, 1'b1, 9'h3, 32'h2, 32'h3);
    checkOutput("dis_level", fifo_level, 0);
    trace_en = 1'b1;
    repeat (20) tick();
    checkOutput("quiet_bytes", rx_byte.size(), 0);

    // Backpressure holds byte 0 on the link.
    rxClear();
    tx_if.tx_ready = 1'b0;
    applyStimulus(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 1'b0, 9'h0, 32'h0, 32'h0);
    ts_e = tsAt(ev_cyc);
    tick();
    for (int i = 0; i < 5; i++) begin
      checkOutput($sformatf("hold_valid%0d", i), tx_if.tx_valid, 1);
      checkOutput($sformatf("hold_data%0d", i), tx_if.tx_data, 8'h81);
      tick();
    end
    tx_if.tx_ready = 1'b1;
    waitBytes(14, 40);
    checkBytes("held", 0, {32'h0, 16'h0, 32'hDEADBEEF, 8'h05, ts_e, 8'h81});

    // One record parked in the serializer, then ten events: eight fit, two drop.
    rxClear();
    tx_if.tx_ready = 1'b0;
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 1'b1, 9'h010, 32'h0, 32'h0);
    tick();
    checkOutput("ovf_parked_level", fifo_level, 0);
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1'b0, 5'd0, 32'h0, 1'b1, 1'b0, 9'(i), 32'(i), 32'h0);
    end
    checkOutput("ovf_level", fifo_level, 8);
    checkOutput("ovf_drop_cnt", drop_cnt, 2);
    checkOutput("ovf_sticky", overflow_sticky, 1);
    tx_if.tx_ready = 1'b1;
    waitBytes(9 * 14, 200);
    checkOutput("ovf_hdr0", byteAt(0), 8'h84);
    for (int r = 1; r < 9; r++) begin
      checkOutput($sformatf("ovf_hdr%0d", r), byteAt(14 * r), 8'h82);
      checkOutput($sformatf("ovf_addr%0d", r), byteAt(14 * r + 8), 8'(r - 1));
    end
    rxClear();
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 1'b1, 9'h020, 32'h0, 32'h0);
    waitBytes(14, 40);
    checkOutput("ovf_flagged_hdr", byteAt(0), 8'hC4);
    rxClear();
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 1'b1, 9'h021, 32'h0, 32'h0);
    waitBytes(14, 40);
    checkOutput("ovf_cleared_hdr", byteAt(0), 8'h84);
    checkOutput("ovf_drop_kept", drop_cnt, 2);
    checkOutput("ovf_sticky_kept", overflow_sticky, 1);

    // Two consecutive events stream as 28 contiguous bytes.
    rxClear();
    applyStimulus(1'b1, 5'd3, 32'hA0A0A0A0, 1'b0, 1'b0, 9'h0, 32'h0, 32'h0);
    t = ev_cyc;
    applyStimulus(1'b1, 5'd4, 32'hB0B0B0B0, 1'b0, 1'b0, 9'h0, 32'h0, 32'h0);
    waitBytes(28, 60);
    ts_a = {byteAt(2), byteAt(1)};
    ts_b = {byteAt(16), byteAt(15)};
    checkOutput("b2b_first", cycAt(0) - t, 2);
    checkOutput("b2b_second", cycAt(14) - t, 16);
    checkOutput("b2b_span", cycAt(27) - cycAt(0), 27);
    checkOutput("b2b_ts_a", ts_a, tsAt(t));
    checkOutput("b2b_ts_diff", ts_b - ts_a, 1);
    checkOutput("b2b_regnum_b", byteAt(17), 8'h04);

    // Reset while byte 6 is on the link abandons the packet and the queue.
    rxClear();
    applyStimulus(1'b1, 5'd7, 32'h77777777, 1'b0, 1'b0, 9'h0, 32'h0, 32'h0);
    applyStimulus(1'b1, 5'd8, 32'h88888888, 1'b0, 1'b0, 9'h0, 32'h0, 32'h0);
    t = 0;
    while (rx_byte.size() < 6 && t < 40) begin
      tick();
      t++;
    end
    checkOutput("mid_bytes_before", rx_byte.size(), 6);
    reset = 1'b1;
    tick();
    checkOutput("mid_tx_valid", tx_if.tx_valid, 0);
    checkOutput("mid_level", fifo_level, 0);
    checkOutput("mid_drop_cnt", drop_cnt, 0);
    checkOutput("mid_sticky", overflow_sticky, 0);
    reset = 1'b0;
    rel_cyc = cyc;
    rxClear();
    applyStimulus(1'b1, 5'd9, 32'h99999999, 1'b0, 1'b0, 9'h0, 32'h0, 32'h0);
    waitBytes(14, 40);
    checkBytes("post_rst", 0, {32'h0, 16'h0, 32'h99999999, 8'h09, 16'h0000, 8'h81});
    repeat (20) tick();
    checkOutput("no_tail", rx_byte.size(), 14);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
